// File: rtl/move_sequencer_pkg.sv
// Shared definitions for the sweep sequencer and the downstream position counter.
//   oper_e  : 2-bit position-counter command (INC / DEC / HOLD)
//   state_e : sequencer FSM state encoding
//   sat_inc : saturating increment used by the reversal counter
package move_sequencer_pkg;

  typedef enum logic [1:0] {
    OPER_HOLD = 2'b00,
    OPER_DEC  = 2'b01,
    OPER_INC  = 2'b10
  } oper_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_MOVE_R = 2'b01,
    ST_MOVE_L = 2'b10
  } state_e;

  localparam int unsigned BOUNCE_W = 8;

  function automatic logic [BOUNCE_W-1:0] sat_inc(input logic [BOUNCE_W-1:0] v);
    return (v == '1) ? v : v + BOUNCE_W'(1);
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Control/status bundle between the sequencer and its surroundings.
//   en, speed, dir_init : run control from the processor output ports
//   x_min, x_max        : bound flags from the position counter
//   oper, step          : per-step command and strobe to the position counter
//   dir, bounce_cnt     : status back to the processor input ports
// master = controller/environment side, slave = sequencer side.
interface move_sequencer_if #(
  parameter int unsigned SPD_W = 8
);
  logic             en;
  logic [SPD_W-1:0] speed;
  logic             dir_init;
  logic             x_min;
  logic             x_max;
  logic [1:0]       oper;
  logic             step;
  logic             dir;
  logic [7:0]       bounce_cnt;

  modport master (
    output en, speed, dir_init, x_min, x_max,
    input  oper, step, dir, bounce_cnt
  );

  modport slave (
    input  en, speed, dir_init, x_min, x_max,
    output oper, step, dir, bounce_cnt
  );
endinterface

// File: rtl/move_sequencer_prescaler.sv
// Base-tick generator: free-running counter 0..PRESC_DIV-1, tick high for
// the single clock in which the count sits at PRESC_DIV-1.
//   clk   : system clock
//   reset : asynchronous, active-high
//   tick  : one-clock pulse every PRESC_DIV clocks
module tick_prescaler #(
  parameter int unsigned PRESC_DIV = 50000,
  parameter int unsigned PRESC_W   = 16
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(PRESC_DIV - 1);

  logic [PRESC_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + PRESC_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/move_sequencer.sv
// Bouncing sweep sequencer: issues one INC/DEC/HOLD command to the position
// counter every `speed` base ticks and reverses on the counter's bound flags.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : move_sequencer_if.slave (run control in, bound flags in,
//           oper/step command out, dir/bounce_cnt status out)
module move_sequencer #(
  parameter int unsigned PRESC_DIV = 50000,
  parameter int unsigned PRESC_W   = 16,
  parameter int unsigned SPD_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  move_sequencer_if.slave   bus
);
  import move_sequencer_pkg::*;

  logic tick;

  tick_prescaler #(
    .PRESC_DIV (PRESC_DIV),
    .PRESC_W   (PRESC_W)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  state_e               state_q, state_d;
  logic [SPD_W-1:0]     interval_q, interval_d;
  logic [1:0]           oper_q, oper_d;
  logic                 step_q, step_d;
  logic                 dir_q, dir_d;
  logic [BOUNCE_W-1:0]  bounce_q, bounce_d;

  // One bit wider than speed so the >= test never wraps.
  logic [SPD_W:0]       interval_nxt;
  logic                 step_due;

  assign interval_nxt = {1'b0, interval_q} + (SPD_W + 1)'(1);
  assign step_due     = tick && (bus.speed != '0) && (interval_nxt >= {1'b0, bus.speed});

  always_comb begin
    state_d    = state_q;
    interval_d = interval_q;
    oper_d     = OPER_HOLD;
    step_d     = 1'b0;
    dir_d      = dir_q;
    bounce_d   = bounce_q;

    case (state_q)
      ST_IDLE: begin
        interval_d = '0;
        if (bus.en) begin
          dir_d   = bus.dir_init;
          state_d = bus.dir_init ? ST_MOVE_L : ST_MOVE_R;
        end
      end

      ST_MOVE_R, ST_MOVE_L: begin
        if (!bus.en) begin
          // Stopping wins over a step due in the same cycle.
          state_d    = ST_IDLE;
          interval_d = '0;
        end else if (tick) begin
          if (bus.speed == '0) begin
            interval_d = '0;
          end else if (step_due) begin
            interval_d = '0;
            step_d     = 1'b1;
            if (bus.x_min && bus.x_max) begin
              // Degenerate bounds: strobe without moving.
              oper_d = OPER_HOLD;
            end else if (state_q == ST_MOVE_R) begin
              if (bus.x_max) begin
                oper_d   = OPER_DEC;
                state_d  = ST_MOVE_L;
                dir_d    = 1'b1;
                bounce_d = sat_inc(bounce_q);
              end else begin
                oper_d   = OPER_INC;
              end
            end else begin
              if (bus.x_min) begin
                oper_d   = OPER_INC;
                state_d  = ST_MOVE_R;
                dir_d    = 1'b0;
                bounce_d = sat_inc(bounce_q);
              end else begin
                oper_d   = OPER_DEC;
              end
            end
          end else begin
            interval_d = interval_nxt[SPD_W-1:0];
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      interval_q <= '0;
      oper_q     <= OPER_HOLD;
      step_q     <= 1'b0;
      dir_q      <= 1'b0;
      bounce_q   <= '0;
    end else begin
      state_q    <= state_d;
      interval_q <= interval_d;
      oper_q     <= oper_d;
      step_q     <= step_d;
      dir_q      <= dir_d;
      bounce_q   <= bounce_d;
    end
  end

  assign bus.oper       = oper_q;
  assign bus.step       = step_q;
  assign bus.dir        = dir_q;
  assign bus.bounce_cnt = bounce_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer with a small position counter
// (bounds N/M) closing the loop on the x_min/x_max flags.
module tb_move_sequencer;
  import move_sequencer_pkg::*;

  localparam int unsigned PD = 4;
  localparam int unsigned PW = 16;
  localparam int unsigned SW = 8;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  move_sequencer_if #(.SPD_W(SW)) bus ();

  move_sequencer #(
    .PRESC_DIV (PD),
    .PRESC_W   (PW),
    .SPD_W     (SW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Position counter environment; ovr forces every step to be a reversal.
  int pos;
  int lim_n = 10;
  int lim_m = 14;
  bit ovr   = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset)                     pos <= 12;
    else if (bus.oper == OPER_INC) pos <= pos + 1;
    else if (bus.oper == OPER_DEC) pos <= pos - 1;
  end

  assign bus.x_min = ovr ? bus.dir  : (pos <= lim_n);
  assign bus.x_max = ovr ? !bus.dir : (pos >= lim_m);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: direction-relative sweep with tick/interval arithmetic.
  bit         m_run, m_dir, m_step;
  int         m_presc, m_int, m_bounce;
  logic [1:0] m_oper;

  task automatic model_reset();
    m_run = 0; m_dir = 0; m_presc = 0; m_int = 0; m_bounce = 0;
    m_oper = OPER_HOLD; m_step = 0;
  endtask

  task automatic model_step();
    bit tk, far, near;
    tk      = (m_presc == PD - 1);
    m_presc = tk ? 0 : m_presc + 1;
    m_oper  = OPER_HOLD;
    m_step  = 0;
    if (!m_run) begin
      m_int = 0;
      if (bus.en) begin m_run = 1; m_dir = bus.dir_init; end
    end else if (!bus.en) begin
      m_run = 0; m_int = 0;
    end else if (tk) begin
      if (bus.speed == 0) m_int = 0;
      else if (m_int + 1 >= int'(bus.speed)) begin
        m_int  = 0;
        m_step = 1;
        far    = m_dir ? bus.x_min : bus.x_max;
        near   = m_dir ? bus.x_max : bus.x_min;
        if (far && near) m_oper = OPER_HOLD;
        else if (far) begin
          m_oper = m_dir ? OPER_INC : OPER_DEC;
          m_dir  = !m_dir;
          if (m_bounce < 255) m_bounce++;
        end else m_oper = m_dir ? OPER_DEC : OPER_INC;
      end else m_int++;
    end
  endtask

  initial model_reset();

  // Per-cycle compare against the model, mid-cycle when everything is settled.
  always @(negedge clk) begin
    if (reset) model_reset();
    check("oper", bus.oper, m_oper);
    check("step", bus.step, m_step);
    check("dir", bus.dir, m_dir);
    check("bounce_cnt", bus.bounce_cnt, m_bounce);
    if (!reset) model_step();
  end

  task automatic tick_edge();
    @(posedge clk); #2;
  endtask

  task automatic edges_until_step(input int limit, output int n);
    n = 0;
    do begin tick_edge(); n++; end while (!bus.step && n < limit);
    if (!bus.step) begin
      n_cmp++; n_fail++;
      $display("FAIL step_timeout: no step within %0d clks, expected one", limit);
    end
  endtask

  initial begin
    int n, cnt;
    bus.en = 1'b0; bus.speed = 8'd2; bus.dir_init = 1'b0;
    #12;
    check("rst_oper", bus.oper, 0);
    check("rst_step", bus.step, 0);
    check("rst_dir", bus.dir, 0);
    check("rst_bounce", bus.bounce_cnt, 0);
    tick_edge();
    reset = 1'b0;

    // Start aligned to prescaler count 3 so the first step lands 9 clks later.
    for (int i = 0; i < 8 && m_presc != PD - 1; i++) tick_edge();
    bus.en = 1'b1;
    edges_until_step(20, n);
    check("first_inc_latency", n, 9);
    check("first_inc_oper", bus.oper, OPER_INC);
    edges_until_step(20, n);
    check("inc_gap", n, 8);
    check("second_inc_oper", bus.oper, OPER_INC);
    tick_edge();
    check("pos_at_max", pos, 14);
    check("x_max_flag", bus.x_max, 1);
    edges_until_step(20, n);
    check("reverse_oper", bus.oper, OPER_DEC);
    check("reverse_dir", bus.dir, 1);
    check("reverse_bounce", bus.bounce_cnt, 1);

    cnt = 0;
    while (bus.bounce_cnt != 2 && cnt < 100) begin tick_edge(); cnt++; end
    check("bounce2_reached", bus.bounce_cnt, 2);
    check("bounce2_pos", pos, 10);
    check("bounce2_oper", bus.oper, OPER_INC);
    check("bounce2_dir", bus.dir, 0);
    cnt = 0;
    while (bus.bounce_cnt != 3 && cnt < 100) begin tick_edge(); cnt++; end
    check("bounce3_reached", bus.bounce_cnt, 3);
    check("bounce3_oper", bus.oper, OPER_DEC);

    // Reset while moving left with a DEC pulse on the output.
    reset = 1'b1; bus.en = 1'b0;
    #1;
    check("midrst_oper", bus.oper, 0);
    check("midrst_dir", bus.dir, 0);
    check("midrst_bounce", bus.bounce_cnt, 0);
    tick_edge();
    reset = 1'b0;

    bus.speed = 8'd0; bus.dir_init = 1'b0; bus.en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin tick_edge(); if (bus.oper != 2'b00 || bus.step) cnt++; end
    check("speed0_no_steps", cnt, 0);

    // Lowering speed below interval+1 steps on the very next tick.
    bus.speed = 8'd5;
    cnt = 0;
    while (m_int != 3 && cnt < 40) begin tick_edge(); cnt++; end
    check("interval3_prescaler", m_presc, 0);
    bus.speed = 8'd2;
    edges_until_step(20, n);
    check("speed_drop_latency", n, 4);
    check("speed_drop_oper", bus.oper, OPER_INC);

    lim_n = 14; lim_m = 10;
    edges_until_step(40, n);
    check("degen_oper", bus.oper, OPER_HOLD);
    check("degen_bounce", bus.bounce_cnt, 0);
    check("degen_dir", bus.dir, 0);
    lim_n = 10; lim_m = 14;

    cnt = 0;
    while (!(m_presc == PD - 1 && m_int + 1 >= int'(bus.speed)) && cnt < 40) begin tick_edge(); cnt++; end
    bus.en = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin tick_edge(); if (bus.step) cnt++; end
    check("en_drop_no_step", cnt, 0);

    bus.dir_init = 1'b1; bus.en = 1'b1;
    edges_until_step(20, n);
    check("restart_left_oper", bus.oper, OPER_DEC);
    check("restart_left_dir", bus.dir, 1);

    ovr = 1'b1; bus.speed = 8'd1;
    cnt = 0;
    while (bus.bounce_cnt != 255 && cnt < 1200) begin tick_edge(); cnt++; end
    for (int i = 0; i < 40; i++) tick_edge();
    check("bounce_saturated", bus.bounce_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
